// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache.
// Holds the cache geometry constants, the memory line-fill request type and the
// FSM state type used by instr_cache.
package instr_cache_pkg;

    localparam int unsigned ICACHE_LINE_WIDTH  = 128;
    localparam int unsigned ICACHE_NUM_LINES   = 4;
    localparam int unsigned PHY_ADDR_WIDTH     = 20;
    localparam int unsigned ICACHE_OFFSET_BITS = 4;
    localparam int unsigned ICACHE_TAG_WIDTH   = PHY_ADDR_WIDTH - ICACHE_OFFSET_BITS;
    localparam int unsigned ICACHE_WAY_BITS    = $clog2(ICACHE_NUM_LINES);

    // Word-select field inside a line (addr[3:2]); used by the requester.
    localparam int unsigned ICACHE_INSTR_IN_LINE_MSB = 3;
    localparam int unsigned ICACHE_INSTR_IN_LINE_LSB = 2;

    typedef struct packed {
        logic [PHY_ADDR_WIDTH-1:0]    addr;
        logic                         is_store;
        logic [ICACHE_LINE_WIDTH-1:0] data;
    } memory_request_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } icache_state_e;

endpackage

// File: rtl/instr_cache.sv
// Blocking, fully associative instruction cache.
// Ports:
//   clock, reset             core clock, asynchronous active-low reset
//   icache_ready             1 = idle and accepting lookups, 0 = miss in flight
//   xcpt_bus_error           pulse in the cycle a line fill returns a bus error
//   req_valid, req_addr      lookup request from fetch (physical byte address)
//   rsp_valid, rsp_data      full line for the request (hit or fill bypass)
//   req_valid_miss           one-cycle line-fill request to memory
//   req_info_miss            line-fill request payload
//   rsp_valid_miss           fill response valid, qualified by rsp_bus_error
//   rsp_data_miss            fill data from memory
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    output logic                         icache_ready,
    output logic                         xcpt_bus_error,
    input  logic                         req_valid,
    input  logic [PHY_ADDR_WIDTH-1:0]    req_addr,
    output logic                         rsp_valid,
    output logic [ICACHE_LINE_WIDTH-1:0] rsp_data,
    output logic                         req_valid_miss,
    output memory_request_t              req_info_miss,
    input  logic [ICACHE_LINE_WIDTH-1:0] rsp_data_miss,
    input  logic                         rsp_bus_error,
    input  logic                         rsp_valid_miss
);

    logic [ICACHE_LINE_WIDTH-1:0] data_q [ICACHE_NUM_LINES];
    logic [ICACHE_TAG_WIDTH-1:0]  tag_q  [ICACHE_NUM_LINES];
    logic [ICACHE_NUM_LINES-1:0]  valid_q;
    logic [ICACHE_WAY_BITS-1:0]   repl_q;
    logic [ICACHE_TAG_WIDTH-1:0]  miss_tag_q;
    icache_state_e                state_q;
    logic                         ready_q;
    logic                         req_miss_q;

    logic [ICACHE_TAG_WIDTH-1:0]  req_tag;
    logic                         hit;
    logic [ICACHE_LINE_WIDTH-1:0] hit_data;
    logic                         lookup;
    logic                         fill_ok;
    logic                         fill_err;

    assign req_tag  = req_addr[PHY_ADDR_WIDTH-1:ICACHE_OFFSET_BITS];
    assign lookup   = (state_q == StIdle) && req_valid;
    assign fill_ok  = (state_q == StWait) && rsp_valid_miss && !rsp_bus_error;
    assign fill_err = (state_q == StWait) && rsp_valid_miss && rsp_bus_error;

    // Tags are never duplicated, so at most one way matches and an OR-mux suffices.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < ICACHE_NUM_LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit      = 1'b1;
                hit_data = hit_data | data_q[i];
            end
        end
    end

    // Fill data is bypassed straight to fetch in the cycle it arrives.
    always_comb begin
        rsp_valid = (lookup && hit) || fill_ok;
        rsp_data  = '0;
        if (fill_ok) begin
            rsp_data = rsp_data_miss;
        end else if (lookup && hit) begin
            rsp_data = hit_data;
        end
    end

    assign xcpt_bus_error         = fill_err;
    assign icache_ready           = ready_q;
    assign req_valid_miss         = req_miss_q;
    assign req_info_miss.addr     = {miss_tag_q, {ICACHE_OFFSET_BITS{1'b0}}};
    assign req_info_miss.is_store = 1'b0;
    assign req_info_miss.data     = '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ready_q    <= 1'b1;
            req_miss_q <= 1'b0;
            valid_q    <= '0;
            repl_q     <= '0;
            miss_tag_q <= '0;
        end else begin
            req_miss_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (lookup && !hit) begin
                        miss_tag_q <= req_tag;
                        state_q    <= StReq;
                        ready_q    <= 1'b0;
                        req_miss_q <= 1'b1;
                    end
                end
                StReq: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (rsp_valid_miss) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        // An erroring fill leaves both the line and the pointer untouched.
                        if (!rsp_bus_error) begin
                            valid_q[repl_q] <= 1'b1;
                            repl_q          <= repl_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Line storage needs no reset: valid_q gates every use.
    always_ff @(posedge clock) begin
        if (fill_ok) begin
            data_q[repl_q] <= rsp_data_miss;
            tag_q[repl_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;
    import instr_cache_pkg::*;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            icache_ready;
    logic            xcpt_bus_error;
    logic            req_valid = 1'b0;
    logic [19:0]     req_addr = '0;
    logic            rsp_valid;
    logic [127:0]    rsp_data;
    logic            req_valid_miss;
    memory_request_t req_info_miss;
    logic [127:0]    rsp_data_miss = '0;
    logic            rsp_bus_error = 1'b0;
    logic            rsp_valid_miss = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model: cache contents in fill order; oldest line is evicted first.
    logic [15:0]  m_tag [$];
    logic [127:0] m_data[$];

    instr_cache dut (
        .clock          (clock),
        .reset          (reset),
        .icache_ready   (icache_ready),
        .xcpt_bus_error (xcpt_bus_error),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .req_valid_miss (req_valid_miss),
        .req_info_miss  (req_info_miss),
        .rsp_data_miss  (rsp_data_miss),
        .rsp_bus_error  (rsp_bus_error),
        .rsp_valid_miss (rsp_valid_miss)
    );

    always #5 clock = ~clock;

    function automatic int model_find(input logic [19:0] a);
        for (int i = 0; i < m_tag.size(); i++) begin
            if (m_tag[i] == a[19:4]) return i;
        end
        return -1;
    endfunction

    function automatic void model_fill(input logic [19:0] a, input logic [127:0] d);
        if (m_tag.size() == ICACHE_NUM_LINES) begin
            void'(m_tag.pop_front());
            void'(m_data.pop_front());
        end
        m_tag.push_back(a[19:4]);
        m_data.push_back(d);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        m_tag.delete();
        m_data.delete();
    endtask

    // Drives one lookup and, on a miss, plays memory with the given latency.
    // Only observes; callers do the comparisons.
    task automatic access(input logic [19:0] a, input int lat, input logic err,
                          input logic [127:0] fill, input logic noise,
                          output logic hit, output logic [127:0] data, output int pulses,
                          output memory_request_t minfo, output logic busy_ok,
                          output logic fill_rv, output logic xcpt, output logic ready_after);
        pulses  = 0;
        minfo   = '0;
        busy_ok = 1'b1;
        fill_rv = 1'b0;
        xcpt    = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        hit  = (rsp_valid === 1'b1);
        data = rsp_data;
        @(negedge clock);
        req_valid = 1'b0;
        if (!hit) begin
            #1;
            if (req_valid_miss === 1'b1) begin
                pulses++;
                minfo = req_info_miss;
            end
            if (icache_ready !== 1'b0) busy_ok = 1'b0;
            for (int c = 0; c < lat; c++) begin
                @(negedge clock);
                if (noise) begin
                    req_valid = 1'($urandom_range(0, 1));
                    req_addr  = 20'($urandom);
                end
                if (c == lat - 1) begin
                    rsp_valid_miss = 1'b1;
                    rsp_bus_error  = err;
                    rsp_data_miss  = fill;
                end
                #1;
                if (req_valid_miss === 1'b1) pulses++;
                if (icache_ready !== 1'b0) busy_ok = 1'b0;
                if (c == lat - 1) begin
                    fill_rv = rsp_valid;
                    data    = rsp_data;
                    xcpt    = xcpt_bus_error;
                end else if (rsp_valid !== 1'b0 || xcpt_bus_error !== 1'b0) begin
                    busy_ok = 1'b0;
                end
            end
            @(negedge clock);
            rsp_valid_miss = 1'b0;
            rsp_bus_error  = 1'b0;
            req_valid      = 1'b0;
        end
        #1;
        ready_after = icache_ready;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (icache_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b exp 1", icache_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        total++; if (req_valid_miss !== 1'b0) begin bad++; $display("FAIL reset_req_miss: got %b exp 0", req_valid_miss); end
        total++; if (xcpt_bus_error !== 1'b0) begin bad++; $display("FAIL reset_xcpt: got %b exp 0", xcpt_bus_error); end
        total++; if (rsp_data !== 128'h0) begin bad++; $display("FAIL reset_rsp_data: got %h exp 0", rsp_data); end
        @(negedge clock);
        reset = 1'b1;
        m_tag.delete();
        m_data.delete();
    endtask

    task automatic test_cold_miss_and_hit();
        logic h, rv, x, ra;
        logic [127:0] d;
        int p;
        memory_request_t mi;
        logic bo;
        logic [127:0] line = 128'hDEAD0001_DEAD0002_DEAD0003_0000BEEF;
        access(20'h01000, 3, 1'b0, line, 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b0) begin bad++; $display("FAIL cold_hit: got %b exp 0", h); end
        total++; if (p != 1) begin bad++; $display("FAIL cold_miss_pulses: got %0d exp 1", p); end
        total++; if (mi !== memory_request_t'{addr: 20'h01000, is_store: 1'b0, data: '0}) begin
            bad++; $display("FAIL cold_miss_info: got addr=%h st=%b exp addr=01000 st=0", mi.addr, mi.is_store); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL cold_busy: got %b exp 1", bo); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL cold_fill_valid: got %b exp 1", rv); end
        total++; if (d !== line) begin bad++; $display("FAIL cold_fill_data: got %h exp %h", d, line); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL cold_ready_after: got %b exp 1", ra); end
        access(20'h0100C, 1, 1'b0, '0, 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b1) begin bad++; $display("FAIL rehit_hit: got %b exp 1", h); end
        total++; if (d !== line) begin bad++; $display("FAIL rehit_data: got %h exp %h", d, line); end
        total++; if (p != 0) begin bad++; $display("FAIL rehit_pulses: got %0d exp 0", p); end
    endtask

    task automatic test_eviction();
        logic h, rv, x, ra, bo;
        logic [127:0] d;
        int p;
        memory_request_t mi;
        logic [127:0] lines[5];
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            lines[i] = {4{32'hA5000000 + 32'(i)}};
            access(20'(i * 16), 1, 1'b0, lines[i], 1'b0, h, d, p, mi, bo, rv, x, ra);
            total++; if (h !== 1'b0 || p != 1) begin
                bad++; $display("FAIL evict_fill%0d: got hit=%b pulses=%0d exp hit=0 pulses=1", i, h, p); end
        end
        access(20'h00010, 1, 1'b0, '0, 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b1 || d !== lines[1]) begin
            bad++; $display("FAIL evict_keep: got hit=%b data=%h exp hit=1 data=%h", h, d, lines[1]); end
        access(20'h00000, 1, 1'b0, lines[0], 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b0 || p != 1) begin
            bad++; $display("FAIL evict_victim: got hit=%b pulses=%0d exp hit=0 pulses=1", h, p); end
    endtask

    task automatic test_bus_error();
        logic h, rv, x, ra, bo;
        logic [127:0] d;
        int p;
        memory_request_t mi;
        logic [127:0] line = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        access(20'h02000, 2, 1'b1, line, 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (x !== 1'b1) begin bad++; $display("FAIL buserr_xcpt: got %b exp 1", x); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL buserr_rsp_valid: got %b exp 0", rv); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL buserr_ready_after: got %b exp 1", ra); end
        access(20'h02004, 1, 1'b0, line, 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b0 || p != 1 || mi.addr !== 20'h02000) begin
            bad++; $display("FAIL buserr_remiss: got hit=%b pulses=%0d addr=%h exp hit=0 pulses=1 addr=02000",
                            h, p, mi.addr); end
        total++; if (x !== 1'b0 || rv !== 1'b1 || d !== line) begin
            bad++; $display("FAIL buserr_refill: got xcpt=%b valid=%b data=%h exp 0 1 %h", x, rv, d, line); end
    endtask

    task automatic test_wait_noise();
        logic h, rv, x, ra, bo;
        logic [127:0] d;
        int p;
        memory_request_t mi;
        logic [127:0] line = rand_line();
        access(20'h05550, 6, 1'b0, line, 1'b1, h, d, p, mi, bo, rv, x, ra);
        total++; if (p != 1) begin bad++; $display("FAIL noise_pulses: got %0d exp 1", p); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL noise_busy: got %b exp 1", bo); end
        total++; if (rv !== 1'b1 || d !== line) begin
            bad++; $display("FAIL noise_fill: got valid=%b data=%h exp 1 %h", rv, d, line); end
    endtask

    task automatic test_reset_mid_miss();
        logic h, rv, x, ra, bo;
        logic [127:0] d;
        int p;
        memory_request_t mi;
        access(20'h03000, 1, 1'b0, rand_line(), 1'b0, h, d, p, mi, bo, rv, x, ra);
        @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 20'h04000;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++; if (icache_ready !== 1'b1 || req_valid_miss !== 1'b0) begin
            bad++; $display("FAIL midreset_state: got ready=%b miss=%b exp 1 0", icache_ready, req_valid_miss); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        rsp_valid_miss = 1'b1;
        rsp_data_miss  = rand_line();
        #1;
        total++; if (rsp_valid !== 1'b0 || xcpt_bus_error !== 1'b0 || icache_ready !== 1'b1) begin
            bad++; $display("FAIL late_rsp: got valid=%b xcpt=%b ready=%b exp 0 0 1",
                            rsp_valid, xcpt_bus_error, icache_ready); end
        @(negedge clock);
        rsp_valid_miss = 1'b0;
        access(20'h04000, 1, 1'b0, rand_line(), 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b0 || p != 1) begin
            bad++; $display("FAIL midreset_nofill: got hit=%b pulses=%0d exp 0 1", h, p); end
        access(20'h03000, 1, 1'b0, rand_line(), 1'b0, h, d, p, mi, bo, rv, x, ra);
        total++; if (h !== 1'b0 || p != 1) begin
            bad++; $display("FAIL midreset_invalid: got hit=%b pulses=%0d exp 0 1", h, p); end
    endtask

    task automatic test_random();
        logic h, rv, x, ra, bo, err, noise, exp_hit;
        logic [127:0] d, fill;
        int p, lat, idx;
        memory_request_t mi;
        logic [19:0] pool[8];
        logic [19:0] a;
        pool = '{20'h00000, 20'h00010, 20'h00020, 20'h7FFF0,
                 20'hFFFF0, 20'h12340, 20'h80000, 20'h00050};
        apply_reset();
        for (int n = 0; n < 200; n++) begin
            a     = pool[$urandom_range(0, 7)] | 20'($urandom_range(0, 15));
            lat   = $urandom_range(1, 4);
            err   = ($urandom_range(0, 7) == 0);
            noise = 1'($urandom_range(0, 1));
            fill  = rand_line();
            idx     = model_find(a);
            exp_hit = (idx >= 0);
            access(a, lat, err, fill, noise, h, d, p, mi, bo, rv, x, ra);
            total++; if (h !== exp_hit) begin
                bad++; $display("FAIL rnd%0d_hit addr=%h: got %b exp %b", n, a, h, exp_hit); end
            if (exp_hit) begin
                total++; if (d !== m_data[idx] || p != 0) begin
                    bad++; $display("FAIL rnd%0d_hitdata: got %h pulses=%0d exp %h pulses=0",
                                    n, d, p, m_data[idx]); end
            end else begin
                total++; if (p != 1 || mi.addr !== {a[19:4], 4'h0} || bo !== 1'b1) begin
                    bad++; $display("FAIL rnd%0d_miss: got pulses=%0d addr=%h busy=%b exp 1 %h 1",
                                    n, p, mi.addr, bo, {a[19:4], 4'h0}); end
                total++; if (x !== err || rv !== !err || (!err && d !== fill)) begin
                    bad++; $display("FAIL rnd%0d_fill: got xcpt=%b valid=%b data=%h exp %b %b %h",
                                    n, x, rv, d, err, !err, fill); end
                if (!err) model_fill(a, fill);
            end
            total++; if (ra !== 1'b1) begin bad++; $display("FAIL rnd%0d_ready: got %b exp 1", n, ra); end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_eviction();
        test_bus_error();
        test_wait_noise();
        test_reset_mid_miss();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
